// File: rtl/kbd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_pkg                                                                  |
// | Shared op encodings, default matrix geometry and FSM states.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package kbd_pkg;

    localparam logic [1:0] KBD_OP_PRESS   = 2'd0;
    localparam logic [1:0] KBD_OP_RELEASE = 2'd1;
    localparam logic [1:0] KBD_OP_RELALL  = 2'd2;
    localparam logic [1:0] KBD_OP_TAP     = 2'd3;

    localparam int KBD_ROWS = 9;
    localparam int KBD_COLS = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_HOLD   = 2'd2
    } kbd_state_e;

endpackage
`default_nettype wire

// File: rtl/kbd_row_sense.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_row_sense                                                            |
// | Registered AND-OR of contact array against the column drive.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module kbd_row_sense
    import kbd_pkg::*;
#(
    parameter int ROWS = KBD_ROWS,
    parameter int COLS = KBD_COLS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*COLS-1:0]   contact_i,
    input  logic [COLS-1:0]        col_i,
    output logic [ROWS-1:0]        row_o
);

    logic [ROWS-1:0] w_row;
    logic [ROWS-1:0] row_q;

    // Each contact is diode-isolated: a row only sees its own closed keys.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign w_row[r] = |(contact_i[r*COLS +: COLS] & col_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
        end else begin
            row_q <= w_row;
        end
    end

    assign row_o = row_q;

endmodule
`default_nettype wire

// File: rtl/kbd_matrix_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_matrix_model                                                         |
// | Command-loaded key matrix with contact bounce and timed taps.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module kbd_matrix_model
    import kbd_pkg::*;
#(
    parameter int ROWS          = KBD_ROWS,
    parameter int COLS          = KBD_COLS,
    parameter int BOUNCE_PERIOD = 16,
    parameter int TAP_HOLD      = 256,
    parameter int BOUNCE_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [3:0]          cmd_row,
    input  logic [3:0]          cmd_col,
    input  logic [BOUNCE_W-1:0] cmd_bounce,
    output logic                cmd_err,
    input  logic [COLS-1:0]     kbd_col,
    output logic [ROWS-1:0]     kbd_row,
    output logic [6:0]          pressed_count,
    output logic                busy
);

    localparam int N_KEYS = ROWS * COLS;
    localparam int KEY_W  = $clog2(N_KEYS);
    localparam int PER_W  = $clog2(BOUNCE_PERIOD + 1);
    localparam int HOLD_W = $clog2(TAP_HOLD + 1);

    localparam logic [PER_W-1:0]  PER_RELOAD = PER_W'(BOUNCE_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(TAP_HOLD);

    kbd_state_e          state_q, state_d;
    logic [N_KEYS-1:0]   contact_q, contact_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                final_q, final_d;
    logic [1:0]          op_q, op_d;
    logic [BOUNCE_W-1:0] bnc_q, bnc_d;
    logic [BOUNCE_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0]    per_q, per_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                err_q, err_d;
    logic                ready_q;
    logic [6:0]          pcnt_q;

    logic                w_accept;
    logic                w_range_err;
    logic [KEY_W-1:0]    w_cmd_key;
    logic [6:0]          w_popcount;

    assign cmd_ready   = ready_q & (state_q == ST_IDLE);
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_range_err = (int'(cmd_row) >= ROWS) || (int'(cmd_col) >= COLS);
    assign w_cmd_key   = KEY_W'(int'(cmd_row) * COLS + int'(cmd_col));

    always_comb begin
        state_d   = state_q;
        contact_d = contact_q;
        key_d     = key_q;
        final_d   = final_q;
        op_d      = op_q;
        bnc_d     = bnc_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        hold_d    = hold_q;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == KBD_OP_RELALL) begin
                        contact_d = '0;
                    end else if (w_range_err) begin
                        err_d = 1'b1;
                    end else begin
                        key_d                = w_cmd_key;
                        final_d              = (cmd_op != KBD_OP_RELEASE);
                        op_d                 = cmd_op;
                        bnc_d                = cmd_bounce;
                        contact_d[w_cmd_key] = (cmd_op != KBD_OP_RELEASE);
                        if (cmd_bounce != '0) begin
                            state_d = ST_BOUNCE;
                            cnt_d   = cmd_bounce;
                            per_d   = PER_RELOAD;
                        end else if (cmd_op == KBD_OP_TAP) begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_LOAD;
                        end
                    end
                end
            end

            ST_BOUNCE: begin
                if (per_q != '0) begin
                    per_d = per_q - 1'b1;
                end else if (cnt_q != '0) begin
                    contact_d[key_q] = ~contact_q[key_q];
                    cnt_d            = cnt_q - 1'b1;
                    per_d            = PER_RELOAD;
                end else begin
                    contact_d[key_q] = final_q;
                    if ((op_q == KBD_OP_TAP) && final_q) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
                // Release phase replays the same bounce count with final = 0.
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    final_d          = 1'b0;
                    contact_d[key_q] = 1'b0;
                    if (bnc_q != '0) begin
                        state_d = ST_BOUNCE;
                        cnt_d   = bnc_q;
                        per_d   = PER_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            w_popcount = w_popcount + 7'(contact_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            contact_q <= '0;
            key_q     <= '0;
            final_q   <= 1'b0;
            op_q      <= KBD_OP_PRESS;
            bnc_q     <= '0;
            cnt_q     <= '0;
            per_q     <= '0;
            hold_q    <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            contact_q <= contact_d;
            key_q     <= key_d;
            final_q   <= final_d;
            op_q      <= op_d;
            bnc_q     <= bnc_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            ready_q   <= 1'b1;
            pcnt_q    <= w_popcount;
        end
    end

    kbd_row_sense #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_row_sense (
        .clk       (clk),
        .rst       (rst),
        .contact_i (contact_q),
        .col_i     (kbd_col),
        .row_o     (kbd_row)
    );

    assign cmd_err       = err_q;
    assign pressed_count = pcnt_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire
